// File: rtl/switch_matrix_cfg_ctrl.sv
// Configuration controller for the routing switch matrix.
// Per-wire driver-select writes arrive over a valid/ready port into a shadow
// table. Each beat is validated as it is accepted. A complete set is scanned
// for 2-wire loops and then committed atomically to active_sel.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   cfg_valid/ready   write beat handshake
//   cfg_addr          target wire index (1..NUM_WIRES)
//   cfg_sel           driver select for that wire (0 = undriven)
//   cfg_last          final beat of a configuration set
//   busy              check/commit in progress
//   commit_done       1-cycle pulse: the new table is live on active_sel
//   err               1-cycle pulse: the set was rejected
//   err_code          1=bad addr, 2=bad sel/self-drive, 3=2-wire loop (held)
//   active_sel        live selects; wire i at [i*SEL_W-1 -: SEL_W]
module switch_matrix_cfg_ctrl #(
  parameter int unsigned NUM_WIRES = 18,
  parameter int unsigned SEL_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [SEL_W-1:0]           cfg_addr,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic                       cfg_last,
  output logic                       busy,
  output logic                       commit_done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [NUM_WIRES*SEL_W-1:0] active_sel
);

  localparam int unsigned TBL_W  = NUM_WIRES * SEL_W;
  localparam int unsigned VIEW_N = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TBL_W-1:0]   shadow_q, shadow_d;
  logic [TBL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               sticky_q, sticky_d;
  logic [1:0]         sticky_code_q, sticky_code_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               commit_done_q, commit_done_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;

  logic [SEL_W-1:0]   sh_view [VIEW_N];
  logic               beat;
  logic               bad_addr;
  logic               bad_sel;
  logic               beat_bad;
  logic [1:0]         beat_code;
  logic [SEL_W-1:0]   scan_sel;
  logic               loop_hit;

  // Unpacked view of the shadow table; entries outside 1..NUM_WIRES read as 0.
  always_comb begin
    for (int i = 0; i < int'(VIEW_N); i++) begin
      sh_view[i] = '0;
    end
    for (int i = 1; i <= int'(NUM_WIRES); i++) begin
      sh_view[i] = shadow_q[i*SEL_W-1 -: SEL_W];
    end
  end

  // Per-beat validation; an out-of-range address takes precedence.
  always_comb begin
    beat      = cfg_valid && cfg_ready_q;
    bad_addr  = (cfg_addr == '0) || (cfg_addr > SEL_W'(NUM_WIRES));
    bad_sel   = (cfg_sel > SEL_W'(NUM_WIRES)) || (cfg_sel == cfg_addr);
    beat_bad  = bad_addr || bad_sel;
    beat_code = bad_addr ? 2'd1 : 2'd2;
  end

  // Loop probe for the wire currently being scanned.
  always_comb begin
    scan_sel = sh_view[idx_q];
    loop_hit = (scan_sel != '0) && (sh_view[scan_sel] == idx_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    idx_d         = idx_q;
    sticky_d      = sticky_q;
    sticky_code_d = sticky_code_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    commit_done_d = 1'b0;

    case (state_q)
      IDLE, LOAD: begin
        if (beat) begin
          state_d = LOAD;
          if (beat_bad) begin
            sticky_d = 1'b1;
            if (!sticky_q) begin
              sticky_code_d = beat_code;
            end
          end else begin
            for (int i = 1; i <= int'(NUM_WIRES); i++) begin
              if (cfg_addr == SEL_W'(i)) begin
                shadow_d[i*SEL_W-1 -: SEL_W] = cfg_sel;
              end
            end
          end
          if (cfg_last) begin
            if (sticky_q || beat_bad) begin
              // Reject the set: report the first error seen, restore the live table.
              err_d         = 1'b1;
              err_code_d    = sticky_q ? sticky_code_q : beat_code;
              shadow_d      = active_q;
              sticky_d      = 1'b0;
              sticky_code_d = 2'd0;
              state_d       = IDLE;
            end else begin
              idx_d   = SEL_W'(1);
              state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (loop_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          shadow_d   = active_q;
          state_d    = IDLE;
        end else if (idx_q == SEL_W'(NUM_WIRES)) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      COMMIT: begin
        active_d      = shadow_q;
        commit_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cfg_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d      = !cfg_ready_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      active_q      <= '0;
      idx_q         <= '0;
      sticky_q      <= 1'b0;
      sticky_code_q <= 2'd0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
      commit_done_q <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      idx_q         <= idx_d;
      sticky_q      <= sticky_d;
      sticky_code_q <= sticky_code_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      commit_done_q <= commit_done_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign active_sel  = active_q;

endmodule

// File: tb/tb_switch_matrix_cfg_ctrl.sv
// Testbench for switch_matrix_cfg_ctrl: table-driven configuration sets,
// scoreboard of expected commit/err outcomes, plus hand-written latency and
// mid-check reset sequences.
module tb_switch_matrix_cfg_ctrl;

  localparam int unsigned NUM_WIRES = 18;
  localparam int unsigned SEL_W     = 5;
  localparam int unsigned TBL_W     = NUM_WIRES * SEL_W;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_addr;
  logic [SEL_W-1:0] cfg_sel;
  logic             cfg_last;
  logic             busy;
  logic             commit_done;
  logic             err;
  logic [1:0]       err_code;
  logic [TBL_W-1:0] active_sel;

  switch_matrix_cfg_ctrl #(.NUM_WIRES(NUM_WIRES), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_sel     (cfg_sel),
    .cfg_last    (cfg_last),
    .busy        (busy),
    .commit_done (commit_done),
    .err         (err),
    .err_code    (err_code),
    .active_sel  (active_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             is_err;
    logic [1:0]       code;
    logic [TBL_W-1:0] active;
  } exp_t;

  typedef struct {
    logic [SEL_W-1:0] addr;
    logic [SEL_W-1:0] sel;
    logic             last;
    logic [1:0]       exp_code;  // 0 = commit expected
  } vec_t;

  exp_t             sb[$];
  vec_t             vec [24];
  int               nvec;
  int               checks;
  int               errors;
  logic [SEL_W-1:0] model_sh  [NUM_WIRES+1];
  logic [SEL_W-1:0] model_act [NUM_WIRES+1];

  function automatic logic [TBL_W-1:0] pack_act();
    logic [TBL_W-1:0] v;
    v = '0;
    for (int i = 1; i <= int'(NUM_WIRES); i++) v[i*SEL_W-1 -: SEL_W] = model_act[i];
    return v;
  endfunction

  // Scoreboard: every commit/err pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (commit_done || err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: commit_done=%0b err=%0b with nothing expected", commit_done, err);
      end else begin
        e = sb.pop_front();
        if (err !== e.is_err || commit_done !== !e.is_err) begin
          errors++;
          $display("FAIL event_kind: err=%0b commit_done=%0b, required err=%0b commit_done=%0b",
                   err, commit_done, e.is_err, !e.is_err);
        end
        checks++;
        if (e.is_err && err_code !== e.code) begin
          errors++;
          $display("FAIL err_code: got %0d, required %0d", err_code, e.code);
        end
        checks++;
        if (active_sel !== e.active) begin
          errors++;
          $display("FAIL active_sel: got %h, required %h", active_sel, e.active);
        end
      end
    end
  end

  task automatic send_beat(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] s, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cfg_ready=%0b, required 1", cfg_ready);
    end else begin
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_sel   = s;
      cfg_last  = l;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      if (a >= 1 && a <= SEL_W'(NUM_WIRES)) model_sh[a] = s;
    end
  endtask

  // Queue the expected outcome of a set whose last beat was just accepted.
  task automatic expect_set(input logic [1:0] code);
    exp_t e;
    if (code == 2'd0) begin
      for (int i = 1; i <= int'(NUM_WIRES); i++) model_act[i] = model_sh[i];
    end else begin
      for (int i = 1; i <= int'(NUM_WIRES); i++) model_sh[i] = model_act[i];
    end
    e.is_err = (code != 2'd0);
    e.code   = code;
    e.active = pack_act();
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !cfg_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outcomes pending, cfg_ready=%0b", sb.size(), cfg_ready);
      sb.delete();
    end
  endtask

  task automatic chk(input string name, input logic [TBL_W-1:0] got, input logic [TBL_W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= int'(NUM_WIRES); i++) begin
      model_sh[i]  = '0;
      model_act[i] = '0;
    end
  endtask

  initial begin
    int lat;
    int seen;

    checks = 0;
    errors = 0;
    nvec   = 0;
    vec[nvec++] = '{5'd3,  5'd9,  1'b0, 2'd0};
    vec[nvec++] = '{5'd3,  5'd4,  1'b1, 2'd0};  // overwrite
    vec[nvec++] = '{5'd0,  5'd5,  1'b1, 2'd1};  // addr 0
    vec[nvec++] = '{5'd7,  5'd7,  1'b1, 2'd2};  // self-drive
    vec[nvec++] = '{5'd5,  5'd19, 1'b1, 2'd2};  // sel out of range
    vec[nvec++] = '{5'd2,  5'd6,  1'b0, 2'd0};
    vec[nvec++] = '{5'd6,  5'd2,  1'b1, 2'd3};  // 2-wire loop
    vec[nvec++] = '{5'd4,  5'd1,  1'b1, 2'd0};
    vec[nvec++] = '{5'd18, 5'd0,  1'b1, 2'd0};  // top wire, undriven
    vec[nvec++] = '{5'd19, 5'd3,  1'b1, 2'd1};  // addr past top
    vec[nvec++] = '{5'd0,  5'd0,  1'b1, 2'd1};  // both violations -> 1
    vec[nvec++] = '{5'd1,  5'd18, 1'b0, 2'd0};
    vec[nvec++] = '{5'd5,  5'd7,  1'b0, 2'd0};
    vec[nvec++] = '{5'd9,  5'd0,  1'b1, 2'd0};
    vec[nvec++] = '{5'd10, 5'd2,  1'b0, 2'd0};
    vec[nvec++] = '{5'd20, 5'd1,  1'b0, 2'd0};  // mid-set error, sticky
    vec[nvec++] = '{5'd11, 5'd3,  1'b1, 2'd1};
    vec[nvec++] = '{5'd12, 5'd5,  1'b1, 2'd0};  // wire10/11 must stay 0

    model_reset();
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_sel   = '0;
    cfg_last  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset_active_sel", active_sel, '0);
    chk("reset_cfg_ready", TBL_W'(cfg_ready), TBL_W'(1));
    chk("reset_busy", TBL_W'(busy), '0);
    chk("reset_commit_done", TBL_W'(commit_done), '0);
    chk("reset_err", TBL_W'(err), '0);
    chk("reset_err_code", TBL_W'(err_code), '0);

    // Single clean beat: commit 19 edges after accept
    send_beat(5'd3, 5'd9, 1'b1);
    expect_set(2'd0);
    chk("check_ready_low", TBL_W'(cfg_ready), '0);
    chk("check_busy_high", TBL_W'(busy), TBL_W'(1));
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (commit_done) lat = k;
    end
    chk("commit_latency", TBL_W'(lat), TBL_W'(19));
    wait_drain();

    // Table-driven sets
    for (int v = 0; v < nvec; v++) begin
      send_beat(vec[v].addr, vec[v].sel, vec[v].last);
      if (vec[v].last) begin
        expect_set(vec[v].exp_code);
        wait_drain();
      end
    end

    // Reset during CHECK: nothing commits, table returns to zero
    send_beat(5'd3, 5'd9, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_active_sel", active_sel, '0);
    chk("midreset_cfg_ready", TBL_W'(cfg_ready), TBL_W'(1));
    chk("midreset_busy", TBL_W'(busy), '0);
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (commit_done || err) seen++;
    end
    chk("midreset_no_event", TBL_W'(seen), '0);

    // Clean set after reset
    send_beat(5'd8, 5'd2, 1'b1);
    expect_set(2'd0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
